// File: rtl/core_pkg.sv
// Shared core types and constants for the front end.
package core_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   cnt;

    // Entry storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy tracking; flush discards everything including a same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC register, same-cycle imem read, fetch queue, redirect handling.
module instruction_fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    output logic [XLEN-1:0]                 imem_addr,
    input  logic [ILEN-1:0]                 imem_rdata,
    input  logic                            redirect_valid,
    input  logic [XLEN-1:0]                 redirect_pc,
    output logic                            dec_valid,
    input  logic                            dec_ready,
    output logic [ILEN-1:0]                 dec_instr,
    output logic [XLEN-1:0]                 dec_pc,
    output logic [$clog2(FQ_DEPTH+1)-1:0]   fq_count
);
    logic [XLEN-1:0] pc;
    logic            pop;
    logic            fetch;
    logic            fq_empty;
    logic            fq_full;
    fetch_entry_t    fq_head;
    fetch_entry_t    fq_in;

    assign imem_addr = pc;
    assign dec_valid = !fq_empty;
    assign pop       = dec_valid && dec_ready;
    // A full queue can still take a new entry when the head leaves in the same cycle.
    assign fetch     = !redirect_valid && (!fq_full || pop);
    assign fq_in     = '{pc: pc, instr: imem_rdata};

    // Program counter: reset, redirect target (word aligned), or sequential advance.
    always_ff @(posedge clk) begin
        if (!rst_n)              pc <= RESET_PC;
        else if (redirect_valid) pc <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (fetch)          pc <= pc + 32'd4;
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (fetch),
        .push_data (fq_in),
        .pop       (pop),
        .head      (fq_head),
        .count     (fq_count),
        .empty     (fq_empty),
        .full      (fq_full)
    );

    // Decode sees zeros rather than stale storage when nothing is queued.
    always_comb begin
        dec_pc    = '0;
        dec_instr = '0;
        if (!fq_empty) begin
            dec_pc    = fq_head.pc;
            dec_instr = fq_head.instr;
        end
    end

endmodule
